// File: rtl/accum_step_sequencer.sv
// ============================================================================
// Module   : accum_step_sequencer
// Purpose  : Command sequencer for the 8-bit nonlinear accumulator
//            acc <= acc + incr/4 + (acc/8)^2. Supports seed load, single
//            step, prescaled run with an iteration limit, and stop.
// Options  : ACC_SAT_EN - saturate acc at 255 instead of wrapping mod 256,
//            and end an unlimited run once acc reaches 255.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_step_sequencer #(
  parameter int DIV   = 4,
  parameter int DIV_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       start,
  input  logic       stop,
  input  logic       step_req,
  input  logic [7:0] incr,
  input  logic [7:0] limit,
  output logic [7:0] acc,
  output logic [7:0] iter_cnt,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] pre, pre_nxt;
  logic [7:0]       lim_q, lim_nxt;
  logic [7:0]       acc_nxt, iter_nxt, iter_inc, upd_val;
  logic             upd, wrap_nxt, ovf;
  logic [9:0]       sq;
  logic [10:0]      sum;

  // Datapath: the square term peaks at 961, so the sum needs 11 bits.
  assign sq       = {5'd0, acc[7:3]} * {5'd0, acc[7:3]};
  assign sum      = {3'd0, acc} + {5'd0, incr[7:2]} + {1'b0, sq};
  assign ovf      = |sum[10:8];
  assign iter_inc = (iter_cnt == 8'hFF) ? 8'hFF : iter_cnt + 8'd1;
`ifdef ACC_SAT_EN
  assign upd_val  = ovf ? 8'hFF : sum[7:0];
`else
  assign upd_val  = sum[7:0];
`endif

  // Next-state decode; command priority is load > stop > start > step_req.
  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    lim_nxt   = lim_q;
    acc_nxt   = acc;
    iter_nxt  = iter_cnt;
    wrap_nxt  = 1'b0;
    upd       = 1'b0;
    if (load) begin
      acc_nxt   = seed;
      iter_nxt  = 8'd0;
      pre_nxt   = '0;
      state_nxt = S_IDLE;
    end else if (stop) begin
      pre_nxt   = '0;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_RUN;
            pre_nxt   = '0;
            iter_nxt  = 8'd0;
            lim_nxt   = limit;
          end else if (step_req) begin
            upd = 1'b1;
          end
        end
        S_RUN: begin
          if (pre == PRE_LAST) begin
            upd     = 1'b1;
            pre_nxt = '0;
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_nxt = S_RUN;
            pre_nxt   = '0;
            iter_nxt  = 8'd0;
            lim_nxt   = limit;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    if (upd) begin
      acc_nxt  = upd_val;
      iter_nxt = iter_inc;
      wrap_nxt = ovf;
      // A run ends on the update that brings the count up to the limit.
      if (state == S_RUN && lim_q != 8'd0 && iter_inc == lim_q)
        state_nxt = S_DONE;
`ifdef ACC_SAT_EN
      // An unlimited run has nothing left to do once acc is pinned at 255.
      if (state == S_RUN && lim_q == 8'd0 && upd_val == 8'hFF)
        state_nxt = S_DONE;
`endif
    end
  end

  // State and output registers; a low ena freezes everything but clears wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pre      <= '0;
      lim_q    <= 8'd0;
      acc      <= 8'd0;
      iter_cnt <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else if (ena) begin
      state    <= state_nxt;
      pre      <= pre_nxt;
      lim_q    <= lim_nxt;
      acc      <= acc_nxt;
      iter_cnt <= iter_nxt;
      busy     <= (state_nxt == S_RUN);
      done     <= (state_nxt == S_DONE);
      wrap     <= wrap_nxt;
    end else begin
      wrap     <= 1'b0;
    end
  end

endmodule

`default_nettype wire
